// File: rtl/mem_store_unit_if.sv
// Store-path bundle: MEM-stage request side plus data-memory write-beat side.
// The store unit uses the slave view; the pipeline/memory environment uses the master view.
interface mem_store_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] addr;
  logic [31:0] din;
  logic [1:0]  memOp;
  logic [1:0]  memSize;
  logic        memReqValid;
  logic        memReqReady;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memWe;
  logic        storeDone;

  modport slave (
    input  reqValid, addr, din, memOp, memSize, memReqReady,
    output reqReady, memReqValid, memAddr, memWdata, memWe, storeDone
  );

  modport master (
    output reqValid, addr, din, memOp, memSize, memReqReady,
    input  reqReady, memReqValid, memAddr, memWdata, memWe, storeDone
  );
endinterface

// File: rtl/mem_store_unit.sv
// Turns a MEM-stage store into one or two word-aligned byte-enabled write beats,
// splitting stores that straddle a 32-bit word boundary.
module mem_store_unit (
  input  logic             clk,
  input  logic             rst,
  mem_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} stateT;

  stateT       stateReg, stateNext;
  logic [29:0] waReg, waNext;
  logic [3:0]  hiWeReg, hiWeNext;
  logic [31:0] hiDataReg, hiDataNext;

  logic        memReqValidReg, memReqValidNext;
  logic [31:0] memAddrReg, memAddrNext;
  logic [31:0] memWdataReg, memWdataNext;
  logic [3:0]  memWeReg, memWeNext;
  logic        storeDoneReg, storeDoneNext;

  logic [1:0]  off;
  logic [3:0]  sizeMask;
  logic [31:0] laneMask;
  logic [7:0]  en8;
  logic [63:0] data64;
  logic        accept;

  assign off = bus.addr[1:0];

  always_comb begin
    case (bus.memSize)
      2'b00:   sizeMask = 4'b0001;
      2'b01:   sizeMask = 4'b0011;
      default: sizeMask = 4'b1111;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gLaneMask
      assign laneMask[8*gi +: 8] = {8{sizeMask[gi]}};
    end
  endgenerate

  // Enables and data are positioned across two words; the upper half is the spill beat.
  assign en8    = {4'b0000, sizeMask} << off;
  assign data64 = {32'h0, bus.din & laneMask} << {off, 3'b000};
  assign accept = bus.reqValid && (stateReg == IDLE) && (bus.memOp == 2'b11);

  always_comb begin
    stateNext       = stateReg;
    waNext          = waReg;
    hiWeNext        = hiWeReg;
    hiDataNext      = hiDataReg;
    memReqValidNext = memReqValidReg;
    memAddrNext     = memAddrReg;
    memWdataNext    = memWdataReg;
    memWeNext       = memWeReg;
    storeDoneNext   = 1'b0;

    case (stateReg)
      IDLE: begin
        if (accept) begin
          stateNext       = SEND_LO;
          waNext          = bus.addr[31:2];
          hiWeNext        = en8[7:4];
          hiDataNext      = data64[63:32];
          memReqValidNext = 1'b1;
          memAddrNext     = {bus.addr[31:2], 2'b00};
          memWeNext       = en8[3:0];
          memWdataNext    = data64[31:0];
        end
      end
      SEND_LO: begin
        if (bus.memReqReady) begin
          if (hiWeReg != 4'b0000) begin
            stateNext    = SEND_HI;
            memAddrNext  = {waReg + 30'd1, 2'b00};
            memWeNext    = hiWeReg;
            memWdataNext = hiDataReg;
          end else begin
            stateNext       = IDLE;
            memReqValidNext = 1'b0;
            storeDoneNext   = 1'b1;
          end
        end
      end
      SEND_HI: begin
        if (bus.memReqReady) begin
          stateNext       = IDLE;
          memReqValidNext = 1'b0;
          storeDoneNext   = 1'b1;
        end
      end
      default: begin
        stateNext       = IDLE;
        memReqValidNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg       <= IDLE;
      waReg          <= '0;
      hiWeReg        <= '0;
      hiDataReg      <= '0;
      memReqValidReg <= 1'b0;
      memAddrReg     <= '0;
      memWdataReg    <= '0;
      memWeReg       <= '0;
      storeDoneReg   <= 1'b0;
    end else begin
      stateReg       <= stateNext;
      waReg          <= waNext;
      hiWeReg        <= hiWeNext;
      hiDataReg      <= hiDataNext;
      memReqValidReg <= memReqValidNext;
      memAddrReg     <= memAddrNext;
      memWdataReg    <= memWdataNext;
      memWeReg       <= memWeNext;
      storeDoneReg   <= storeDoneNext;
    end
  end

  assign bus.reqReady    = ~rst & (stateReg == IDLE);
  assign bus.memReqValid = memReqValidReg;
  assign bus.memAddr     = memAddrReg;
  assign bus.memWdata    = memWdataReg;
  assign bus.memWe       = memWeReg;
  assign bus.storeDone   = storeDoneReg;

endmodule

// File: doc/mem_store_unit.md
# mem_store_unit

Store-path companion to the load-side memory output logic: it takes a store request from the MEM stage and turns it into one or two word-aligned write beats toward data memory. For each beat it drives byte-lane enables and lane-shifted write data. A store that crosses a 32-bit word boundary is split into two beats. The block sits between the MEM-stage control (`memOp`/`memSize`/`addr`) and the data-memory write port, with a valid/ready handshake on both sides and a completion pulse back to the pipeline.

## Interface
Parameters: none.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — reset; asynchronous, active-high.
- `reqValid` in 1 — MEM stage presents a request.
- `reqReady` out 1 — block idle and able to accept a request; 0 while `rst` is high.
- `addr` in 32 — byte address of the store.
- `din` in 32 — store data, right-justified (byte in `[7:0]`, half in `[15:0]`).
- `memOp` in 2 — `2'b11` = store; `00` = none; `01`/`10` = loads, which this block ignores.
- `memSize` in 2 — `00` = byte, `01` = half, `10` = word, `11` = treated as word.
- `memReqValid` out 1 — write beat valid.
- `memReqReady` in 1 — memory accepts the beat.
- `memAddr` out 32 — word-aligned address (`[1:0]` = 0).
- `memWdata` out 32 — lane-positioned data; disabled lanes are driven 0.
- `memWe` out 4 — byte enables; bit i = byte lane i.
- `storeDone` out 1 — one-cycle pulse; all beats of the store were accepted.

## Operation
- **Accept:** a request is taken when `reqValid & reqReady & memOp==2'b11`.
  - `reqValid` with any other `memOp` is ignored: no beats, no `storeDone`, state unchanged.
- **Registered at accept:**
  - `off = addr[1:0]`
  - `wa = addr[31:2]`
  - `sizeMask` = `0001` (byte), `0011` (half), `1111` (word)
  - `en8 = sizeMask << off` (8 bits)
  - `data64 = (din & lane mask) << (8*off)` (64 bits)
- **Beat 0:** `memAddr = {wa,2'b00}`, `memWe = en8[3:0]`, `memWdata = data64[31:0]`.
- **Beat 1:** issued only when `en8[7:4] != 0`. `memAddr = {wa+1,2'b00}`, `memWe = en8[7:4]`, `memWdata = data64[63:32]`.
  - `wa+1` is 30-bit modular: address `0xFFFFFFFC` wraps to `0x00000000`.
- **FSM states:**
  - IDLE
    - `reqReady=1`, `memReqValid=0`.
    - On accept → SEND_LO.
  - SEND_LO
    - `memReqValid=1` with beat 0.
    - On `memReqReady` → SEND_HI if a split is needed; otherwise → IDLE and pulse `storeDone`.
  - SEND_HI
    - `memReqValid=1` with beat 1.
    - On `memReqReady` → IDLE and pulse `storeDone`.
- **Stability:** while `memReqValid=1` and `memReqReady=0`, `memAddr`, `memWdata` and `memWe` hold stable.
- **Reset values:**
  - Outputs: `memReqValid=0`, `memAddr=0`, `memWdata=0`, `memWe=0`, `storeDone=0`, `reqReady=0`.
  - State: IDLE.
- **Reset mid-operation:**
  - `memReqValid` drops immediately (asynchronous); no `storeDone`; state returns to IDLE.
  - A beat 0 already accepted is not rolled back.

## Timing
- All outputs except `reqReady` are registered. `reqReady = ~rst & (state==IDLE)`.
- With accept in cycle N and `memReqReady` tied high:
  - Aligned store: beat 0 valid in cycle N+1; `storeDone` in N+2.
  - Split store: beat 0 in N+1, beat 1 in N+2, `storeDone` in N+3.
- `storeDone` is asserted the cycle after the final handshake. The state is IDLE in that cycle, so a new request may be accepted in the same cycle as `storeDone`.
- Each cycle of `memReqReady=0` adds exactly one cycle of latency.
- No request is accepted while in SEND_LO or SEND_HI.

## Test plan
- **Byte store:** `addr=0x1003`, `din=0xFFFFFFAB`, `memSize=00` → a single beat with `memAddr=0x1000`, `memWdata=0xAB000000`, `memWe=1000`; `storeDone` 2 cycles after accept.
- **Split word:** `addr=0x2002`, `din=0xDEADBEEF`, `memSize=10` →
  - beat 0: `0x2000` / `0xBEEF0000` / `1100`
  - beat 1: `0x2004` / `0x0000DEAD` / `0011`
  - `storeDone` 3 cycles after accept.
- **Split half:** `addr=0x3003`, `din=0x00001234`, `memSize=01` →
  - beat 0: `0x3000` / `0x34000000` / `1000`
  - beat 1: `0x3004` / `0x00000012` / `0001`
- **Backpressure:** aligned word at `0x4000` with `memReqReady` low for 3 cycles → outputs held constant for 4 valid cycles; exactly one handshake; `storeDone` once. In the same run, `memOp=01` with `reqValid` high → no beat is issued.
- **Wrap-around:** `addr=0xFFFFFFFE`, `din=0x11223344`, word →
  - beat 0: `0xFFFFFFFC` / `0x33440000` / `1100`
  - beat 1: `0x00000000` / `0x00001122` / `0011`
- **Reset during split:** assert `rst` in the SEND_HI cycle → `memReqValid=0` that same cycle; `storeDone` never pulses; after `rst` deasserts, `reqReady=1` and a new aligned store completes normally.
